// File: rtl/clcd_seq_ctrl.sv
// clcd_seq_ctrl: host-programmable sequencer for the character LCD port.
// The host pushes {RS, byte} entries into a small FIFO. The block drains the
// FIFO and generates RS/DQ setup, a clean E strobe, a hold phase and the
// post-command wait, so software never toggles E directly.
//
// Optional feature macro: CLCD_IRQ_EN (drain-complete interrupt).
//
// Ports:
//   clk, nRESET          system clock, asynchronous active-low reset
//   HOST_nCS/nWE/nOE     host strobes, active low
//   HOST_ADD[19:0]       host address (data BASE, status BASE+2, control BASE+4)
//   HDI[15:0]            host write data
//   HDO[15:0]            registered host read data (status)
//   CLCD_RS/RW/E/DQ      LCD bus (RW tied low, write-only)
//   CLCD_INT             drain-complete interrupt level
module clcd_seq_ctrl #(
   parameter logic [19:0] BASE_ADDR    = 20'h00100,
   parameter int unsigned FIFO_DEPTH   = 8,
   parameter int unsigned SETUP_CYC    = 4,
   parameter int unsigned E_HIGH_CYC   = 25,
   parameter int unsigned CMD_WAIT_CYC = 2500,
   parameter int unsigned CLR_WAIT_CYC = 82000
) (
   input  logic        clk,
   input  logic        nRESET,
   input  logic        HOST_nCS,
   input  logic        HOST_nWE,
   input  logic        HOST_nOE,
   input  logic [19:0] HOST_ADD,
   input  logic [15:0] HDI,
   output logic [15:0] HDO,
   output logic        CLCD_RS,
   output logic        CLCD_RW,
   output logic        CLCD_E,
   output logic [7:0]  CLCD_DQ,
   output logic        CLCD_INT
);

   localparam int unsigned AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW      = AW + 1;
   localparam int unsigned MAX_A   = (SETUP_CYC > E_HIGH_CYC) ? SETUP_CYC : E_HIGH_CYC;
   localparam int unsigned MAX_B   = (CMD_WAIT_CYC > CLR_WAIT_CYC) ? CMD_WAIT_CYC : CLR_WAIT_CYC;
   localparam int unsigned MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int unsigned TW      = $clog2(MAX_CYC + 1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_WAIT} state_t;

   // ---------------- host interface ----------------
   logic        wr_act_c, rd_act_c, fire_c;
   logic        push_c, ctrl_c, accept_c, flush_c, ovf_clr_c;
   logic        wr_q;
   logic [8:0]  hdi_q;
   logic [19:0] add_q;
   logic        unused_hdi_c;

   assign wr_act_c  = !HOST_nCS && !HOST_nWE && HOST_nOE;
   assign rd_act_c  = !HOST_nCS && !HOST_nOE && (HOST_ADD == BASE_ADDR + 20'd2);
   // Action fires on the first edge after the write condition drops
   assign fire_c    = wr_q && !wr_act_c;
   assign push_c    = fire_c && (add_q == BASE_ADDR);
   assign ctrl_c    = fire_c && (add_q == BASE_ADDR + 20'd4);
   assign flush_c   = ctrl_c && hdi_q[0];
   assign ovf_clr_c = ctrl_c && hdi_q[1];
   assign unused_hdi_c = ^HDI[15:9];

   // Capture write data/address every active write cycle
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         wr_q  <= 1'b0;
         hdi_q <= '0;
         add_q <= '0;
      end else begin
         wr_q <= wr_act_c;
         if (wr_act_c) begin
            hdi_q <= HDI[8:0];
            add_q <= HOST_ADD;
         end
      end
   end

   // ---------------- FIFO ----------------
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          ovf_q, empty_c, full_c, pop_c;
   logic [8:0]    head_c;

   assign empty_c  = (count_q == '0);
   assign full_c   = (count_q == CW'(FIFO_DEPTH));
   // A full FIFO drops the push even if a pop happens on the same edge
   assign accept_c = push_c && !full_c;
   assign head_c   = mem[rd_ptr_q];

   // Entry storage (contents are don't-care until written)
   always_ff @(posedge clk) begin
      if (accept_c) mem[wr_ptr_q] <= hdi_q;
   end

   // Pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         if (accept_c) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (flush_c)    rd_ptr_q <= wr_ptr_q;
         else if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
         if (flush_c)                   count_q <= '0;
         else if (accept_c && !pop_c)   count_q <= count_q + CW'(1);
         else if (!accept_c && pop_c)   count_q <= count_q - CW'(1);
         if (push_c && full_c) ovf_q <= 1'b1;
         else if (ovf_clr_c)   ovf_q <= 1'b0;
      end
   end

   // ---------------- sequencer FSM ----------------
   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic          rs_q, rs_d, clr_q, clr_d, e_q;
   logic [7:0]    dq_q, dq_d;

   // Next-state, timer and LCD bus values
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + TW'(1);
      rs_d    = rs_q;
      dq_d    = dq_q;
      clr_d   = clr_q;
      pop_c   = 1'b0;
      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (!empty_c) begin
               pop_c   = 1'b1;
               rs_d    = head_c[8];
               dq_d    = head_c[7:0];
               clr_d   = !head_c[8] && (head_c[7:0] inside {8'h01, 8'h02, 8'h03});
               state_d = S_SETUP;
            end
         end
         S_SETUP: if (tmr_q == TW'(SETUP_CYC - 1)) begin
            tmr_d   = '0;
            state_d = S_STROBE;
         end
         S_STROBE: if (tmr_q == TW'(E_HIGH_CYC - 1)) begin
            tmr_d   = '0;
            state_d = S_HOLD;
         end
         S_HOLD: if (tmr_q == TW'(SETUP_CYC - 1)) begin
            tmr_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: if (tmr_q == (clr_q ? TW'(CLR_WAIT_CYC - 1) : TW'(CMD_WAIT_CYC - 1))) begin
            tmr_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            tmr_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State register; E is registered from the next state so it never glitches
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         rs_q    <= 1'b0;
         dq_q    <= '0;
         clr_q   <= 1'b0;
         e_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         rs_q    <= rs_d;
         dq_q    <= dq_d;
         clr_q   <= clr_d;
         e_q     <= (state_d == S_STROBE);
      end
   end

   // ---------------- interrupt ----------------
   logic int_pend_c;
`ifdef CLCD_IRQ_EN
   logic int_q;
   // Set on WAIT->IDLE with nothing left to drain; a coinciding read loses
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET)                                            int_q <= 1'b0;
      else if (state_q == S_WAIT && state_d == S_IDLE && empty_c) int_q <= 1'b1;
      else if (rd_act_c)                                      int_q <= 1'b0;
   end
   assign int_pend_c = int_q;
`else
   assign int_pend_c = 1'b0;
`endif

   // ---------------- status read ----------------
   logic [15:0] status_c;
   assign status_c = {7'd0, int_pend_c, 4'(count_q), ovf_q, full_c, empty_c,
                      (state_q != S_IDLE)};

   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET)       HDO <= '0;
      else if (rd_act_c) HDO <= status_c;
   end

   assign CLCD_RS  = rs_q;
   assign CLCD_RW  = 1'b0;
   assign CLCD_E   = e_q;
   assign CLCD_DQ  = dq_q;
   assign CLCD_INT = int_pend_c;

endmodule

// File: tb/tb_clcd_seq_ctrl.sv
// Scoreboard bench for clcd_seq_ctrl: stimulus queues expected E pulses and
// status words; monitors pop and compare when the DUT presents them.
module tb_clcd_seq_ctrl;

   localparam logic [19:0] BASE = 20'h00100;
`ifdef CLCD_IRQ_EN
   localparam logic [15:0] MSK = 16'hFEFF;
`else
   localparam logic [15:0] MSK = 16'hFFFF;
`endif

   logic        clk, nRESET;
   logic        HOST_nCS, HOST_nWE, HOST_nOE;
   logic [19:0] HOST_ADD;
   logic [15:0] HDI, HDO;
   logic        CLCD_RS, CLCD_RW, CLCD_E, CLCD_INT;
   logic [7:0]  CLCD_DQ;

   clcd_seq_ctrl #(
      .BASE_ADDR(BASE), .FIFO_DEPTH(8), .SETUP_CYC(2), .E_HIGH_CYC(3),
      .CMD_WAIT_CYC(5), .CLR_WAIT_CYC(20)
   ) dut (
      .clk(clk), .nRESET(nRESET), .HOST_nCS(HOST_nCS), .HOST_nWE(HOST_nWE),
      .HOST_nOE(HOST_nOE), .HOST_ADD(HOST_ADD), .HDI(HDI), .HDO(HDO),
      .CLCD_RS(CLCD_RS), .CLCD_RW(CLCD_RW), .CLCD_E(CLCD_E),
      .CLCD_DQ(CLCD_DQ), .CLCD_INT(CLCD_INT)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rs;
      logic [7:0] dq;
      int         rise;
   } pulse_t;

   typedef struct {
      string       name;
      logic [15:0] val;
      logic [15:0] msk;
   } stat_t;

   pulse_t pq[$];
   stat_t  sq[$];
   int     n_tests = 0;
   int     n_fail  = 0;
   int     cyc     = 0;
   int     int_high = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- E pulse monitor ----------------
   logic   e_prev = 1'b0;
   logic   in_pulse = 1'b0;
   int     rise_cyc = 0;
   pulse_t pe;

   always @(negedge clk) begin
      if (CLCD_INT) int_high++;
      if (!nRESET) begin
         e_prev   = 1'b0;
         in_pulse = 1'b0;
      end else begin
         if (CLCD_E && !e_prev) begin
            rise_cyc = cyc;
            in_pulse = 1'b1;
            if (pq.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pulse: got rs=%0b dq=%0h at cyc %0d, required none",
                        CLCD_RS, CLCD_DQ, cyc);
            end else begin
               pe = pq.pop_front();
               chk({pe.name, "_rs"}, 32'(CLCD_RS), 32'(pe.rs));
               chk({pe.name, "_dq"}, 32'(CLCD_DQ), 32'(pe.dq));
               chk({pe.name, "_rise_cyc"}, 32'(cyc), 32'(pe.rise));
            end
         end
         if (!CLCD_E && e_prev && in_pulse) begin
            chk("e_width", 32'(cyc - rise_cyc), 32'd3);
            in_pulse = 1'b0;
         end
         e_prev = CLCD_E;
      end
   end

   // ---------------- status monitor ----------------
   logic  rd_seen = 1'b0;
   stat_t se;

   always @(posedge clk)
      rd_seen <= nRESET && !HOST_nCS && !HOST_nOE && (HOST_ADD == BASE + 20'd2);

   always @(negedge clk) begin
      if (rd_seen) begin
         if (sq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_read: got %0h, required no read", HDO);
         end else begin
            se = sq.pop_front();
            chk(se.name, 32'(HDO & se.msk), 32'(se.val & se.msk));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic host_wr(input logic [19:0] a, input logic [15:0] d, output int pc);
      @(posedge clk); #1;
      HOST_ADD = a; HDI = d; HOST_nCS = 1'b0; HOST_nWE = 1'b0; HOST_nOE = 1'b1;
      @(posedge clk); #1;
      HOST_nCS = 1'b1; HOST_nWE = 1'b1;
      pc = cyc + 1;
   endtask

   task automatic host_rd(input string name, input logic [15:0] v, input logic [15:0] m);
      stat_t s;
      s.name = name; s.val = v; s.msk = m;
      @(posedge clk); #1;
      sq.push_back(s);
      HOST_ADD = BASE + 20'd2; HOST_nCS = 1'b0; HOST_nOE = 1'b0; HOST_nWE = 1'b1;
      @(posedge clk); #1;
      HOST_nCS = 1'b1; HOST_nOE = 1'b1;
   endtask

   task automatic exp_pulse(input string name, input logic rs, input logic [7:0] dq, input int rise);
      pulse_t p;
      p.name = name; p.rs = rs; p.dq = dq; p.rise = rise;
      pq.push_back(p);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   int p, pd;

   initial begin
      nRESET = 1'b0; HOST_nCS = 1'b1; HOST_nWE = 1'b1; HOST_nOE = 1'b1;
      HOST_ADD = '0; HDI = '0;
      repeat (3) @(posedge clk);
      #1 nRESET = 1'b1;

      // Power-on reset state
      @(negedge clk);
      chk("rst_outputs", {HDO, CLCD_DQ, 4'd0, CLCD_RS, CLCD_RW, CLCD_E, CLCD_INT}, 32'd0);
      host_rd("rst_status", 16'h0002, 16'hFFFF);

      // Single normal entry
      host_wr(BASE, 16'h0141, p);
      exp_pulse("single", 1'b1, 8'h41, p + 3);
      wait_until(p + 20);

      // Back-to-back normal entries: 13 clk rise-to-rise
      host_wr(BASE, 16'h0141, p);
      exp_pulse("b2b_a", 1'b1, 8'h41, p + 3);
      exp_pulse("b2b_b", 1'b1, 8'h42, p + 16);
      host_wr(BASE, 16'h0142, pd);
      wait_until(p + 35);

      // Clear followed by normal: 28 clk rise-to-rise
      host_wr(BASE, 16'h0001, p);
      exp_pulse("clr_a", 1'b0, 8'h01, p + 3);
      exp_pulse("clr_b", 1'b1, 8'h41, p + 31);
      host_wr(BASE, 16'h0141, pd);
      wait_until(p + 50);

      // Overflow while the FSM is held in a long clear wait
      host_wr(BASE, 16'h0001, p);
      exp_pulse("ovf_clr", 1'b0, 8'h01, p + 3);
      for (int k = 0; k < 9; k++) begin
         host_wr(BASE, 16'h0130 + 16'(k), pd);
         if (k < 8) exp_pulse("ovf_entry", 1'b1, 8'h30 + 8'(k), p + 31 + 13 * k);
      end
      host_rd("ovf_full", 16'h008D, MSK);
      host_wr(BASE + 20'd4, 16'h0002, pd);
      host_rd("ovf_cleared", 16'h0085, MSK);
      wait_until(p + 31 + 13 * 7 + 20);
      host_rd("ovf_drained", 16'h0002, MSK);

      // Flush mid-STROBE: current pulse completes, no further pulses
      host_wr(BASE, 16'h0002, p);
      exp_pulse("fl_home", 1'b0, 8'h02, p + 3);
      exp_pulse("fl_first", 1'b1, 8'h50, p + 31);
      for (int k = 0; k < 4; k++) host_wr(BASE, 16'h0150 + 16'(k), pd);
      wait_until(p + 30);
      host_wr(BASE + 20'd4, 16'h0001, pd);
      host_rd("flush_status", 16'h0003, MSK);
      wait_until(p + 100);
      host_rd("flush_idle", 16'h0002, MSK);

`ifdef CLCD_IRQ_EN
      // Interrupt on final drain, cleared by a status read
      host_rd("irq_pre_clear", 16'h0002, MSK);
      host_wr(BASE, 16'h0160, p);
      exp_pulse("irq_a", 1'b1, 8'h60, p + 3);
      exp_pulse("irq_b", 1'b1, 8'h61, p + 16);
      host_wr(BASE, 16'h0161, pd);
      wait_until(p + 14);
      chk("int_not_yet", 32'(CLCD_INT), 32'd0);
      wait_until(p + 25);
      chk("int_before_idle", 32'(CLCD_INT), 32'd0);
      wait_until(p + 26);
      chk("int_set", 32'(CLCD_INT), 32'd1);
      host_rd("irq_status", 16'h0102, 16'hFFFF);
      @(negedge clk);
      chk("int_cleared", 32'(CLCD_INT), 32'd0);
`endif

      // Reset mid-STROBE aborts immediately and loses queued entries
      host_wr(BASE, 16'h0155, p);
      exp_pulse("rst_pulse", 1'b1, 8'h55, p + 3);
      host_wr(BASE, 16'h0156, pd);
      wait_until(p + 4);
      chk("rst_e_high_before", 32'(CLCD_E), 32'd1);
      #2 nRESET = 1'b0;
      #1 chk("rst_e_async", 32'(CLCD_E), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1 nRESET = 1'b1;
      @(negedge clk);
      chk("rst2_outputs", {HDO, CLCD_DQ, 4'd0, CLCD_RS, CLCD_RW, CLCD_E, CLCD_INT}, 32'd0);
      host_rd("rst2_status", 16'h0002, 16'hFFFF);
      repeat (30) @(negedge clk);

      // Bounded drain of outstanding expectations
      for (int i = 0; i < 500 && (pq.size() != 0 || sq.size() != 0); i++) @(negedge clk);
      chk("pulses_outstanding", 32'(pq.size()), 32'd0);
      chk("reads_outstanding", 32'(sq.size()), 32'd0);
`ifndef CLCD_IRQ_EN
      chk("int_const0", 32'(int_high), 32'd0);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
